// File: rtl/seq_multiplier.sv
// seq_multiplier: 32x32 unsigned shift-and-add multiplier producing a 64-bit product.
// Latency: 33 cycles from the accepting edge (32 busy cycles, then one done cycle).
// Backpressure: none; start is accepted only when busy=0 and ignored while busy.

// adder64: plain 64-bit adder with carry in/out, used for the accumulate step.
module adder64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        carryIn,
  output logic [63:0] sum,
  output logic        carryOut
);

  logic [64:0] total;

  assign total    = {1'b0, a} + {1'b0, b} + {64'b0, carryIn};
  assign sum      = total[63:0];
  assign carryOut = total[64];

endmodule

module seq_multiplier (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [63:0] product,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] product_q, product_d;

  logic [63:0] add_sum;
  logic        add_carry_unused;
  logic [63:0] acc_step;

  // A 32-bit multiplicand shifted at most 31 places into a 64-bit accumulator
  // can never overflow, so the carry out is left dangling.
  adder64 u_adder (
    .a        (acc_q),
    .b        (mcand_q),
    .carryIn  (1'b0),
    .sum      (add_sum),
    .carryOut (add_carry_unused)
  );

  // Accumulator value after the current partial product is conditionally added.
  assign acc_step = mplier_q[0] ? add_sum : acc_q;

  // Next-state and datapath update: load on accept, one shift-add per RUN cycle.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = {32'b0, multiplicand};
          mplier_d = multiplier;
          acc_d    = 64'b0;
          count_d  = 6'd0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        count_d  = count_q + 6'd1;
        // The last step's sum goes straight into the product register so the
        // result is visible in the DONE cycle itself.
        if (count_q == 6'd31) begin
          product_d = acc_step;
          state_d   = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the product.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      mcand_q   <= 64'b0;
      mplier_q  <= 32'b0;
      acc_q     <= 64'b0;
      count_q   <= 6'd0;
      product_q <= 64'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: constant vectors, corner sequences
// and a randomized regression against a 64-bit arithmetic reference.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] product;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_product;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  seq_multiplier dut (
    .clk          (clk),
    .rstN         (rstN),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Present a start with operands on the low phase; returns right after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
  endtask

  // Follow one operation cycle by cycle: busy for 32 cycles, then done with the product.
  // Optionally pulse a spurious start mid-run, or chain a new start in the done cycle.
  task automatic wait_op(input logic [63:0] exp, input string tag, input int inject_at,
                         input bit chain, input logic [31:0] ca, input logic [31:0] cb);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
      if (inject_at != 0 && c == inject_at) begin
        start        = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
      end
      if (inject_at != 0 && c == inject_at + 1) start = 1'b0;
      if (c <= 32) begin
        chk($sformatf("%s busy c%0d", tag, c), 64'(busy), 64'd1);
        chk($sformatf("%s done c%0d", tag, c), 64'(done), 64'd0);
        chk($sformatf("%s hold c%0d", tag, c), product, last_product);
      end else begin
        chk($sformatf("%s busy at done", tag), 64'(busy), 64'd0);
        chk($sformatf("%s done pulse", tag), 64'(done), 64'd1);
        chk($sformatf("%s product", tag), product, exp);
      end
    end
    last_product = exp;
    if (chain) begin
      start        = 1'b1;
      multiplicand = ca;
      multiplier   = cb;
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk($sformatf("%s idle busy", tag), 64'(busy), 64'd0);
    chk($sformatf("%s idle done", tag), 64'(done), 64'd0);
    chk($sformatf("%s idle product", tag), product, last_product);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rexp;

    vecs[0] = '{32'd3,          32'd5,          64'd15};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,          32'h1234_5678,  64'd0};
    vecs[3] = '{32'd1,          32'd1,          64'd1};
    vecs[4] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    vecs[5] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
    vecs[6] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[7] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
    vecs[8] = '{32'h1234_5678,  32'd0,          64'd0};

    rstN         = 1'b1;
    start        = 1'b0;
    multiplicand = 32'd0;
    multiplier   = 32'd0;
    last_product = 64'd0;

    #1 rstN = 1'b0;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", product, 64'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    check_idle("post reset");

    // Constant vectors, each followed by an idle check.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_op(vecs[i].p, $sformatf("vec%0d", i), 0, 1'b0, 32'd0, 32'd0);
      check_idle($sformatf("vec%0d", i));
    end

    // A start during RUN must be ignored.
    issue(32'd7, 32'd6);
    wait_op(64'd42, "ignore", 10, 1'b0, 32'd0, 32'd0);
    check_idle("ignore");

    // Reset mid-run aborts immediately; start is ignored while reset is held.
    issue(32'd100, 32'd200);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      chk($sformatf("abort busy c%0d", c), 64'(busy), 64'd1);
    end
    #2 rstN = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort product", product, 64'd0);
    last_product = 64'd0;
    start        = 1'b1;
    multiplicand = 32'd5;
    multiplier   = 32'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("in reset busy", 64'(busy), 64'd0);
      chk("in reset done", 64'(done), 64'd0);
      chk("in reset product", product, 64'd0);
    end
    start = 1'b0;
    rstN  = 1'b1;
    for (int c = 0; c < 3; c++) check_idle("after abort");
    issue(32'd2, 32'd3);
    wait_op(64'd6, "after abort", 0, 1'b0, 32'd0, 32'd0);
    check_idle("after abort");

    // Back-to-back: a start in the done cycle chains straight into a new run.
    issue(32'd10, 32'd10);
    wait_op(64'd100, "b2b first", 0, 1'b1, 32'd4, 32'd5);
    @(posedge clk);
    wait_op(64'd20, "b2b second", 0, 1'b0, 32'd0, 32'd0);
    check_idle("b2b");

    // Randomized regression against plain 64-bit multiplication; every other
    // operation is chained to exercise the done-cycle accept.
    ra = pick();
    rb = pick();
    issue(ra, rb);
    for (int n = 0; n < 1000; n++) begin
      bit          chain;
      logic [31:0] na, nb;
      rexp  = {32'd0, ra} * {32'd0, rb};
      chain = (n % 2 == 0) && (n != 999);
      na    = pick();
      nb    = pick();
      wait_op(rexp, $sformatf("rand%0d %0h*%0h", n, ra, rb), 0, chain, na, nb);
      if (n != 999) begin
        if (chain) begin
          @(posedge clk);
        end else begin
          check_idle($sformatf("rand%0d", n));
          issue(na, nb);
        end
      end
      ra = na;
      rb = nb;
    end
    check_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
